// File: rtl/constraint_eval_pipe.sv
// Two-stage constraint evaluator: S1 latches the per-slot pass mask of an accepted sample,
// S2 presents it with the AND-reduced satisfied flag, and saturating counters tally transfers.
module constraint_eval_pipe #(
    parameter  int N_VARS = 10,
    parameter  int VAR_W  = 32,
    parameter  int N_CONS = 8,
    parameter  int CNT_W  = 16,
    localparam int IW     = (N_VARS > 1) ? $clog2(N_VARS) : 1,
    localparam int CW     = (N_CONS > 1) ? $clog2(N_CONS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [CW-1:0]           cfg_idx,
    input  logic                    cfg_en,
    input  logic [2:0]              cfg_op,
    input  logic [IW-1:0]           cfg_a,
    input  logic [IW-1:0]           cfg_b,
    input  logic [VAR_W-1:0]        cfg_k,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_VARS*VAR_W-1:0] in_vars,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_CONS-1:0]       out_mask,
    output logic                    out_sat,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        pass_cnt,
    output logic [CNT_W-1:0]        fail_cnt
);

    typedef enum logic [2:0] {
        OP_LAND, OP_LNOT_NE, OP_EQ_K, OP_NE_K, OP_LT_K, OP_GE_K, OP_EQ_V, OP_NE_V
    } op_e;

    logic              en_q [N_CONS];
    op_e               op_q [N_CONS];
    logic [IW-1:0]     a_q  [N_CONS];
    logic [IW-1:0]     b_q  [N_CONS];
    logic [VAR_W-1:0]  k_q  [N_CONS];

    logic              s1_valid_q;
    logic [N_CONS-1:0] s1_mask_q;
    logic              out_valid_q;
    logic [N_CONS-1:0] out_mask_q;
    logic              out_sat_q;
    logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
    logic [N_CONS-1:0] eval_mask;

    // Out-of-range indices select nothing, so they read as zero.
    function automatic logic [VAR_W-1:0] pick(input logic [IW-1:0] idx,
                                              input logic [N_VARS*VAR_W-1:0] vars);
        logic [VAR_W-1:0] r;
        r = '0;
        for (int i = 0; i < N_VARS; i++)
            if (idx == IW'(i)) r = vars[i*VAR_W +: VAR_W];
        return r;
    endfunction

    function automatic logic eval_slot(input logic en, input op_e op, input logic [VAR_W-1:0] va,
                                       input logic [VAR_W-1:0] vb, input logic [VAR_W-1:0] k);
        logic r;
        case (op)
            OP_LAND:    r = (va != '0) && (vb != '0);
            OP_LNOT_NE: r = VAR_W'(~|va) != vb;
            OP_EQ_K:    r = va == k;
            OP_NE_K:    r = va != k;
            OP_LT_K:    r = va < k;
            OP_GE_K:    r = va >= k;
            OP_EQ_V:    r = va == vb;
            default:    r = va != vb;
        endcase
        return en ? r : 1'b1;
    endfunction

    always_comb begin
        eval_mask = '1;
        for (int c = 0; c < N_CONS; c++)
            eval_mask[c] = eval_slot(en_q[c], op_q[c], pick(a_q[c], in_vars),
                                     pick(b_q[c], in_vars), k_q[c]);
    end

    logic s2_take, s1_adv, in_acc, out_xfer;
    assign out_xfer = out_valid_q && out_ready;
    assign s2_take  = !out_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_take;
    assign in_ready = rst_n && (!s1_valid_q || s2_take);
    assign in_acc   = in_valid && in_ready;

    // NOTE: slot registers are a small register file, not RAM, so they take the reset
    // value; a sample arriving right after reset must see every slot disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CONS; c++) begin
                en_q[c] <= 1'b0;
                op_q[c] <= OP_LAND;
                a_q[c]  <= '0;
                b_q[c]  <= '0;
                k_q[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < N_CONS; c++) begin
                if (cfg_we && cfg_idx == CW'(c)) begin
                    en_q[c] <= cfg_en;
                    op_q[c] <= op_e'(cfg_op);
                    a_q[c]  <= cfg_a;
                    b_q[c]  <= cfg_b;
                    k_q[c]  <= cfg_k;
                end
            end
        end
    end

    // NOTE: non-blocking assignments let S2 read S1's old contents while S1 loads a new
    // sample on the same edge; blocking ones would collapse the two stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_mask_q   <= '0;
            out_valid_q <= 1'b0;
            out_mask_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            if (in_acc) begin
                s1_valid_q <= 1'b1;
                s1_mask_q  <= eval_mask;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end
            if (s1_adv) begin
                out_valid_q <= 1'b1;
                out_mask_q  <= s1_mask_q;
                out_sat_q   <= &s1_mask_q;
            end else if (out_xfer) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // NOTE: the hold-value defaults come first so no path leaves a counter unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        if (cnt_clr) begin
            pass_cnt_d = '0;
            fail_cnt_d = '0;
        end else if (out_xfer) begin
            if (out_sat_q) begin
                if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + 1'b1;
            end else begin
                if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_mask  = out_mask_q;
    assign out_sat   = out_sat_q;
    assign pass_cnt  = pass_cnt_q;
    assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_constraint_eval_pipe.sv
// Randomized bench for constraint_eval_pipe: a negedge monitor scores every handshake
// against a queue-based model of the slot rules; directed sequences cover the edge cases.
module tb_constraint_eval_pipe;

    localparam int NV = 10;
    localparam int VW = 32;
    localparam int NC = 8;
    localparam int CB = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_we;
    logic [2:0]        cfg_idx;
    logic              cfg_en;
    logic [2:0]        cfg_op;
    logic [3:0]        cfg_a, cfg_b;
    logic [VW-1:0]     cfg_k;
    logic              in_valid, in_ready;
    logic [NV*VW-1:0]  in_vars;
    logic              out_valid, out_ready;
    logic [NC-1:0]     out_mask;
    logic              out_sat;
    logic              cnt_clr;
    logic [CB-1:0]     pass_cnt, fail_cnt;

    constraint_eval_pipe #(.N_VARS(NV), .VAR_W(VW), .N_CONS(NC), .CNT_W(CB)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_op(cfg_op), .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_k(cfg_k),
        .in_valid(in_valid), .in_ready(in_ready), .in_vars(in_vars),
        .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask), .out_sat(out_sat),
        .cnt_clr(cnt_clr), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: slot table, in-flight results, saturating tallies.
    logic        m_en [NC];
    int          m_op [NC];
    int          m_a  [NC];
    int          m_b  [NC];
    logic [31:0] m_k  [NC];
    logic [NC-1:0] exp_q[$];
    logic [NC-1:0] got_q[$];
    int          m_pass, m_fail, xfer_cnt;
    logic [NC-1:0] e;

    function automatic logic [NC-1:0] model_mask(input logic [NV*VW-1:0] pv);
        logic [31:0]   v [NV];
        logic [31:0]   va, vb;
        logic [NC-1:0] m;
        for (int i = 0; i < NV; i++) v[i] = pv[i*VW +: VW];
        for (int c = 0; c < NC; c++) begin
            va = (m_a[c] < NV) ? v[m_a[c]] : 32'd0;
            vb = (m_b[c] < NV) ? v[m_b[c]] : 32'd0;
            if (!m_en[c]) m[c] = 1'b1;
            else case (m_op[c])
                0: m[c] = (va != 0) && (vb != 0);
                1: m[c] = ((va == 0) ? 32'd1 : 32'd0) != vb;
                2: m[c] = va == m_k[c];
                3: m[c] = va != m_k[c];
                4: m[c] = va < m_k[c];
                5: m[c] = va >= m_k[c];
                6: m[c] = va == vb;
                default: m[c] = va != vb;
            endcase
        end
        return m;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_pass = 0;
            m_fail = 0;
            for (int c = 0; c < NC; c++) begin
                m_en[c] = 1'b0; m_op[c] = 0; m_a[c] = 0; m_b[c] = 0; m_k[c] = '0;
            end
        end else begin
            check("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
            check("pass_cnt", pass_cnt, m_pass);
            check("fail_cnt", fail_cnt, m_fail);
            e = '1;
            if (out_valid && out_ready) begin
                check("out_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_mask", out_mask, e);
                    check("out_sat", out_sat, &e);
                end
                got_q.push_back(out_mask);
                xfer_cnt++;
            end
            if (cnt_clr) begin
                m_pass = 0;
                m_fail = 0;
            end else if (out_valid && out_ready) begin
                if (&e) m_pass = (m_pass < 15) ? m_pass + 1 : 15;
                else    m_fail = (m_fail < 15) ? m_fail + 1 : 15;
            end
            if (in_valid && in_ready) exp_q.push_back(model_mask(in_vars));
            if (cfg_we) begin
                m_en[cfg_idx] = cfg_en; m_op[cfg_idx] = int'(cfg_op);
                m_a[cfg_idx] = int'(cfg_a); m_b[cfg_idx] = int'(cfg_b); m_k[cfg_idx] = cfg_k;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NV*VW-1:0] v);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        in_valid = 1'b1;
        in_vars  = v;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        if (!acc) check("send_timeout", n, 0);
        in_valid = 1'b0;
    endtask

    task automatic cfg_set(input int idx, input logic en, input int op, input int a,
                           input int b, input logic [31:0] k);
        cfg_idx = 3'(idx); cfg_en = en; cfg_op = 3'(op);
        cfg_a = 4'(a); cfg_b = 4'(b); cfg_k = k;
    endtask

    task automatic cfg_write(input int idx, input logic en, input int op, input int a,
                             input int b, input logic [31:0] k);
        cfg_set(idx, en, op, a, b, k);
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain", exp_q.size(), 0);
        tick();
    endtask

    function automatic logic [NV*VW-1:0] rand_vars();
        logic [NV*VW-1:0] r;
        for (int i = 0; i < NV; i++)
            r[i*VW +: VW] = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 3));
        return r;
    endfunction

    logic [NV*VW-1:0] sv;
    int               base, n;
    logic             done;

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_vars = '0; xfer_cnt = 0;
        cfg_set(0, 1'b0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_mask", out_mask, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_in_ready", in_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // All slots disabled: an all-zero sample passes with 2-cycle latency.
        in_valid = 1'b1;
        in_vars  = '0;
        @(negedge clk);
        check("t1_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_not_yet", out_valid, 0);
        tick();
        @(negedge clk);
        check("t1_out_valid", out_valid, 1);
        check("t1_mask", out_mask, 8'hFF);
        check("t1_sat", out_sat, 1);
        tick();
        @(negedge clk);
        check("t1_pass_cnt", pass_cnt, 1);
        tick();

        cfg_write(0, 1'b1, 0, 4, 1, 0);
        cfg_write(1, 1'b1, 1, 7, 1, 0);
        cfg_write(2, 1'b1, 2, 7, 0, 32'h37FD);
        sv = '0;
        sv[1*VW +: VW] = 32'd5;
        sv[4*VW +: VW] = 32'd3;
        sv[7*VW +: VW] = 32'h37FD;
        base = got_q.size();
        send(sv);
        sv[7*VW +: VW] = 32'h37FC;
        send(sv);
        drain();
        check("t2_mask_a", got_q[base], 8'hFF);
        check("t2_mask_b", got_q[base+1], 8'hFB);
        @(negedge clk);
        check("t2_fail_cnt", fail_cnt, 1);
        check("t2_pass_cnt", pass_cnt, 2);
        tick();

        // Slot write coincident with acceptance: old value first, new value next.
        sv = '0;
        sv[0 +: VW] = 32'd50;
        base = got_q.size();
        cfg_set(3, 1'b1, 5, 0, 0, 32'd100);
        cfg_we = 1'b1;
        send(sv);
        cfg_we = 1'b0;
        send(sv);
        drain();
        check("t4_old_cfg", got_q[base][3], 1);
        check("t4_new_cfg", got_q[base+1][3], 0);

        // Random slots, 20 back-to-back samples under random backpressure.
        for (int c = 0; c < NC; c++)
            cfg_write(c, $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      32'($urandom_range(0, 3)));
        base = xfer_cnt;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) send(rand_vars());
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        drain();
        check("t3_xfer_count", xfer_cnt - base, 20);

        // Saturation at 2^4-1, then clear coincident with a transfer.
        for (int c = 0; c < NC; c++) cfg_write(c, 1'b0, 0, 0, 0, 0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        for (int i = 0; i < 17; i++) send('0);
        drain();
        @(negedge clk);
        check("t5_pass_sat", pass_cnt, 15);
        tick();
        out_ready = 1'b0;
        send(rand_vars());
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_wait_valid", out_valid, 1);
        tick();
        cnt_clr = 1'b1;
        out_ready = 1'b1;
        tick();
        cnt_clr = 1'b0;
        @(negedge clk);
        check("t5_clr_pass", pass_cnt, 0);
        check("t5_clr_fail", fail_cnt, 0);
        tick();

        // Reset with both stages full.
        out_ready = 1'b0;
        send(rand_vars());
        send(rand_vars());
        @(negedge clk);
        check("t6_full_stall", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_ready", in_ready, 0);
        @(negedge clk);
        check("t6_rst_ready_hold", in_ready, 0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_post_ready", in_ready, 1);
            check("t6_post_valid", out_valid, 0);
        end
        check("t6_post_pass", pass_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
